// File: rtl/uart_fmt_pkg.sv
// Shared types and helpers for the UART number formatter.
// Holds the FSM state enum, ASCII constants and digit encoders.
package uart_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND,
        SEP
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    // 0-9 map to '0'..'9', 10-15 map to 'A'..'F'
    function automatic logic [7:0] nib2ascii(input logic [3:0] d);
        if (d < 4'd10)
            return ASCII_ZERO + {4'd0, d};
        else
            return ASCII_A + {4'd0, d - 4'd10};
    endfunction

    // Decimal digits needed for the largest w-bit value
    function automatic int dec_digits(input int w);
        longint m;
        int     n;
        m = (longint'(1) << w) - 1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m > 0) begin
                n++;
                m = m / 10;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_num_formatter_bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// Ports: clk, rst_n, start (load bin), bin, done (1-cycle pulse), bcd.
module bin2bcd_seq
    import uart_fmt_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEC_DIGITS = dec_digits(DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    done,
    output logic [4*DEC_DIGITS-1:0] bcd
);

    localparam int BW = 4 * DEC_DIGITS;
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sh;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // The load cycle already performs the first shift (no digit can
    // need correction yet), so DATA_W shifts finish DATA_W-1 cycles
    // after start and done lines up with the last cycle of CONV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd <= BW'(bin[DATA_W-1]);
                sh  <= {bin[DATA_W-2:0], 1'b0};
                cnt <= CW'(DATA_W - 1);
            end else if (cnt != '0) begin
                {bcd, sh} <= {adj[BW-2:0], sh, 1'b0};
                cnt       <= cnt - 1'b1;
                done      <= (cnt == CW'(1));
            end
        end
    end

endmodule

// File: rtl/uart_num_formatter.sv
// Formats received values as ASCII decimal/hex and streams them to uart_tx.
// Ports: clk, rst_n, in_valid/in_data (FIFO push), radix_hex, zero_sup,
// sep_en (latched at pop), tx_done in; tx_start, tx_char, busy,
// fifo_level, drop_cnt out.
module uart_num_formatter
    import uart_fmt_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SEP_CHAR   = 8'h20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        radix_hex,
    input  logic                        zero_sup,
    input  logic                        sep_en,
    input  logic                        tx_done,
    output logic                        tx_start,
    output logic [7:0]                  tx_char,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  drop_cnt
);

    localparam int DEC_DIGITS = dec_digits(DATA_W);
    localparam int HEX_DIGITS = (DATA_W + 3) / 4;
    localparam int DW         = 4 * DEC_DIGITS;
    localparam int IW         = $clog2(DEC_DIGITS);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int LW         = AW + 1;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    logic [DATA_W-1:0] val;
    logic              hex_q;
    logic              zs_q;
    logic              sep_q;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     nxt_idx;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     first;
    logic              conv_done;
    logic [DW-1:0]     bcd;
    logic [DW-1:0]     digs;

    assign push    = in_valid && (fifo_level != LW'(FIFO_DEPTH));
    assign pop     = (state == IDLE) && (fifo_level != '0);
    assign head    = mem[rd_ptr];
    assign busy    = (state != IDLE);
    assign digs    = hex_q ? DW'(val) : bcd;
    assign nxt_idx = idx - 1'b1;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;
            if (in_valid && !push && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    bin2bcd_seq #(
        .DATA_W    (DATA_W),
        .DEC_DIGITS(DEC_DIGITS)
    ) u_bcd (
        .clk  (clk),
        .rst_n(rst_n),
        .start(pop),
        .bin  (head),
        .done (conv_done),
        .bcd  (bcd)
    );

    // Most significant digit to send; with suppression this is the
    // highest non-zero digit, falling back to digit 0 for a zero value.
    always_comb begin
        top_idx = hex_q ? IW'(HEX_DIGITS - 1) : IW'(DEC_DIGITS - 1);
        first   = top_idx;
        if (zs_q) begin
            first = '0;
            for (int i = 1; i < DEC_DIGITS; i++) begin
                if (IW'(i) <= top_idx && digs[4*i +: 4] != 4'd0)
                    first = IW'(i);
            end
        end
    end

    // A tx_done coinciding with tx_start belongs to no launched frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            val      <= '0;
            hex_q    <= 1'b0;
            zs_q     <= 1'b0;
            sep_q    <= 1'b0;
            idx      <= '0;
            tx_start <= 1'b0;
            tx_char  <= '0;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        val   <= head;
                        hex_q <= radix_hex;
                        zs_q  <= zero_sup;
                        sep_q <= sep_en;
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        idx      <= first;
                        tx_start <= 1'b1;
                        tx_char  <= nib2ascii(digs[4*first +: 4]);
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_done && !tx_start) begin
                        if (idx == '0) begin
                            if (sep_q) begin
                                tx_start <= 1'b1;
                                tx_char  <= SEP_CHAR;
                                state    <= SEP;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx      <= nxt_idx;
                            tx_start <= 1'b1;
                            tx_char  <= nib2ascii(digs[4*nxt_idx +: 4]);
                        end
                    end
                end
                SEP: begin
                    if (tx_done && !tx_start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_num_formatter.sv
// Self-checking bench for uart_num_formatter (8-bit and 16-bit builds).
// Emulates uart_tx with random frame lengths and checks the character stream.
module tb_uart_num_formatter;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  val;
        bit          hex;
        bit          zs;
        bit          sep;
        int          n;
        logic [47:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       in_valid8, hex8, zs8, sep8, resp_done8, man_done8, tx_done8;
    logic [7:0] in_data8;
    logic       tx_start8, busy8;
    logic [7:0] tx_char8, drop8;
    logic [2:0] lvl8;

    logic        in_valid16, hex16, zs16, sep16, resp_done16, tx_done16;
    logic [15:0] in_data16;
    logic        tx_start16, busy16;
    logic [7:0]  tx_char16, drop16;
    logic [2:0]  lvl16;

    bq_t got8, got16;
    int  st8[$], st16[$];
    int  cd8 = -1, cd16 = -1;
    int  proto8 = 0, proto16 = 0;
    bit  auto8 = 1'b1;

    assign tx_done8  = resp_done8 | man_done8;
    assign tx_done16 = resp_done16;

    uart_num_formatter #(
        .DATA_W(8), .FIFO_DEPTH(4), .SEP_CHAR(8'h20)
    ) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_data(in_data8),
        .radix_hex(hex8), .zero_sup(zs8), .sep_en(sep8),
        .tx_done(tx_done8), .tx_start(tx_start8), .tx_char(tx_char8),
        .busy(busy8), .fifo_level(lvl8), .drop_cnt(drop8)
    );

    uart_num_formatter #(
        .DATA_W(16), .FIFO_DEPTH(4), .SEP_CHAR(8'h20)
    ) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_data(in_data16),
        .radix_hex(hex16), .zero_sup(zs16), .sep_en(sep16),
        .tx_done(tx_done16), .tx_start(tx_start16), .tx_char(tx_char16),
        .busy(busy16), .fifo_level(lvl16), .drop_cnt(drop16)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // uart_tx stand-ins: log each launched char, answer with tx_done later
    initial begin
        resp_done8 = 1'b0;
        forever begin
            @(posedge clk); #1;
            resp_done8 = 1'b0;
            if (tx_start8) begin
                if (!busy8 || cd8 >= 0) proto8++;
                got8.push_back(tx_char8);
                st8.push_back(cyc);
                cd8 = auto8 ? int'($urandom_range(0, 3)) : -1;
            end else if (cd8 == 0) begin
                resp_done8 = 1'b1;
                cd8 = -1;
            end else if (cd8 > 0) begin
                cd8--;
            end
        end
    end

    initial begin
        resp_done16 = 1'b0;
        forever begin
            @(posedge clk); #1;
            resp_done16 = 1'b0;
            if (tx_start16) begin
                if (!busy16 || cd16 >= 0) proto16++;
                got16.push_back(tx_char16);
                st16.push_back(cyc);
                cd16 = int'($urandom_range(0, 3));
            end else if (cd16 == 0) begin
                resp_done16 = 1'b1;
                cd16 = -1;
            end else if (cd16 > 0) begin
                cd16--;
            end
        end
    end

    // Reference formatting straight from the number's arithmetic value
    function automatic bq_t fmt(input int unsigned v, input int w,
                                input bit hex, input bit zs, input bit sep);
        bq_t         q;
        int          n;
        bit          lead;
        int unsigned d, p;
        n = hex ? (w + 3) / 4 : int'($ceil($log10(2.0 ** w)));
        lead = zs;
        for (int i = n - 1; i >= 0; i--) begin
            if (hex) begin
                d = (v >> (4 * i)) & 15;
            end else begin
                p = 1;
                for (int j = 0; j < i; j++) p = p * 10;
                d = (v / p) % 10;
            end
            if (d != 0 || i == 0) lead = 1'b0;
            if (!lead)
                q.push_back(d < 10 ? 8'h30 + 8'(d) : 8'h41 + 8'(d - 10));
        end
        if (sep) q.push_back(8'h20);
        return q;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmpq(input string nm, input bq_t a, input bq_t e);
        int bad;
        bad = -1;
        checks++;
        if (a.size() != e.size()) begin
            errors++;
            $display("FAIL %s: got %0d chars expected %0d",
                     nm, a.size(), e.size());
        end else begin
            foreach (e[i])
                if (bad < 0 && a[i] !== e[i]) bad = i;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s: char %0d got %h expected %h",
                         nm, bad, a[bad], e[bad]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push8(input logic [7:0] v);
        in_data8  = v;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
    endtask

    task automatic wait_idle8(input string nm);
        int n;
        n = 0;
        while ((busy8 || lvl8 != 0) && n < 3000) begin
            step();
            n++;
        end
        chk({nm, " timeout"}, 64'(n >= 3000), 64'd0);
    endtask

    vec_t tab[10];

    initial begin
        bq_t exp;
        bq_t tmp;
        int  b, t0, lat, sz, n, k;
        logic [7:0] v8;

        tab[0] = '{8'd65,  1'b0, 1'b0, 1'b1, 4, 48'h30363520};
        tab[1] = '{8'd7,   1'b0, 1'b1, 1'b0, 1, 48'h37};
        tab[2] = '{8'd0,   1'b0, 1'b1, 1'b0, 1, 48'h30};
        tab[3] = '{8'hAF,  1'b1, 1'b0, 1'b0, 2, 48'h4146};
        tab[4] = '{8'h05,  1'b1, 1'b1, 1'b0, 1, 48'h35};
        tab[5] = '{8'd255, 1'b0, 1'b1, 1'b1, 4, 48'h32353520};
        tab[6] = '{8'd0,   1'b1, 1'b0, 1'b1, 3, 48'h303020};
        tab[7] = '{8'd100, 1'b0, 1'b1, 1'b0, 3, 48'h313030};
        tab[8] = '{8'd10,  1'b0, 1'b1, 1'b0, 2, 48'h3130};
        tab[9] = '{8'h09,  1'b1, 1'b0, 1'b1, 3, 48'h303920};

        rst_n = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; man_done8 = 1'b0;
        hex8 = 1'b0; zs8 = 1'b0; sep8 = 1'b0;
        in_valid16 = 1'b0; in_data16 = '0;
        hex16 = 1'b0; zs16 = 1'b0; sep16 = 1'b0;
        repeat (3) step();
        chk("reset8", {tx_start8, busy8, lvl8, drop8, tx_char8}, 64'd0);
        chk("reset16", {tx_start16, busy16, lvl16, drop16, tx_char16}, 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            exp = {};
            for (int j = tab[i].n - 1; j >= 0; j--)
                exp.push_back(tab[i].e[8*j +: 8]);
            hex8 = tab[i].hex; zs8 = tab[i].zs; sep8 = tab[i].sep;
            b = got8.size();
            t0 = cyc;
            push8(tab[i].val);
            wait_idle8($sformatf("vec%0d", i));
            cmpq($sformatf("vec%0d", i), got8[b:$], exp);
            if (i == 0) begin
                lat = (st8.size() > b) ? st8[b] - t0 : -1;
                chk("latency8", 64'(lat), 64'd10);
            end
        end

        // Six back-to-back values into a 4-deep FIFO: the sixth is dropped
        hex8 = 1'b0; zs8 = 1'b0; sep8 = 1'b1;
        b = got8.size();
        exp = {};
        for (int v = 1; v <= 6; v++) begin
            push8(8'(v));
            if (v <= 5) begin
                tmp = fmt(v, 8, 1'b0, 1'b0, 1'b1);
                foreach (tmp[i]) exp.push_back(tmp[i]);
            end
        end
        chk("burst_level_full", 64'(lvl8), 64'd4);
        wait_idle8("burst");
        cmpq("burst_order", got8[b:$], exp);
        chk("burst_drop_cnt", 64'(drop8), 64'd1);

        // Reset in the middle of a number, then a stray tx_done
        auto8 = 1'b0;
        hex8 = 1'b0; zs8 = 1'b0; sep8 = 1'b0;
        b = got8.size();
        push8(8'd123);
        n = 0;
        while (got8.size() == b && n < 100) begin
            step();
            n++;
        end
        chk("midsend_first_start timeout", 64'(n >= 100), 64'd0);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("midsend_reset", {tx_start8, busy8, lvl8, drop8, tx_char8}, 64'd0);
        rst_n = 1'b1;
        step();
        man_done8 = 1'b1;
        step();
        man_done8 = 1'b0;
        sz = got8.size();
        repeat (20) step();
        chk("stray_no_start", 64'(got8.size()), 64'(sz));
        chk("stray_level", 64'(lvl8), 64'd0);
        chk("stray_busy", 64'(busy8), 64'd0);
        auto8 = 1'b1;
        zs8 = 1'b1;
        b = got8.size();
        push8(8'd42);
        wait_idle8("after_reset");
        cmpq("after_reset", got8[b:$], fmt(42, 8, 1'b0, 1'b1, 1'b0));

        // Random batches of up to five values, modes fixed per batch
        for (int r = 0; r < 30; r++) begin
            hex8 = 1'($urandom_range(0, 1));
            zs8  = 1'($urandom_range(0, 1));
            sep8 = 1'($urandom_range(0, 1));
            k = int'($urandom_range(1, 5));
            b = got8.size();
            exp = {};
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 3) == 0)
                    v8 = 8'($urandom_range(0, 15));
                else
                    v8 = 8'($urandom_range(0, 255));
                tmp = fmt(v8, 8, hex8, zs8, sep8);
                foreach (tmp[i]) exp.push_back(tmp[i]);
                push8(v8);
            end
            wait_idle8($sformatf("rand%0d", r));
            cmpq($sformatf("rand%0d", r), got8[b:$], exp);
        end

        // 16-bit build: 65535, then a queued value with modes changed mid-number
        hex16 = 1'b0; zs16 = 1'b0; sep16 = 1'b0;
        b = got16.size();
        t0 = cyc;
        in_data16 = 16'd65535;
        in_valid16 = 1'b1;
        step();
        in_data16 = 16'h00A5;
        step();
        in_valid16 = 1'b0;
        n = 0;
        while (got16.size() == b && n < 100) begin
            step();
            n++;
        end
        chk("w16_first_start timeout", 64'(n >= 100), 64'd0);
        hex16 = 1'b1; zs16 = 1'b1; sep16 = 1'b1;
        lat = (st16.size() > b) ? st16[b] - t0 : -1;
        chk("latency16", 64'(lat), 64'd18);
        n = 0;
        while ((busy16 || lvl16 != 0) && n < 3000) begin
            step();
            n++;
        end
        chk("w16 timeout", 64'(n >= 3000), 64'd0);
        exp = fmt(65535, 16, 1'b0, 1'b0, 1'b0);
        tmp = fmt(16'h00A5, 16, 1'b1, 1'b1, 1'b1);
        foreach (tmp[i]) exp.push_back(tmp[i]);
        cmpq("w16_stream", got16[b:$], exp);

        chk("protocol8", 64'(proto8), 64'd0);
        chk("protocol16", 64'(proto16), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
